// File: rtl/alu_driver_if.sv
// Request, ALU and response signal bundle for alu_driver.
// The slave modport is the driver itself; the master modport is its environment.
interface alu_driver_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [3:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_op1;
    logic [WIDTH-1:0] alu_op2;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       alu_flags;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_flags;
    logic             rsp_err;

    logic [3:0]       sticky_flags;
    logic             sticky_clr;

    modport slave (
        input  req_valid, req_op, req_a, req_b,
        input  alu_result, alu_flags,
        input  rsp_ready, sticky_clr,
        output req_ready,
        output alu_ctrl, alu_op1, alu_op2,
        output rsp_valid, rsp_result, rsp_flags, rsp_err,
        output sticky_flags
    );

    modport master (
        output req_valid, req_op, req_a, req_b,
        output alu_result, alu_flags,
        output rsp_ready, sticky_clr,
        input  req_ready,
        input  alu_ctrl, alu_op1, alu_op2,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  sticky_flags
    );
endinterface

// File: rtl/alu_driver.sv
// Sequences one operation at a time through an external combinational ALU into a 2-entry response FIFO.
// Define ALU_DRIVER_STICKY_FLAGS_EN to accumulate pushed flags into sticky_flags.
module alu_driver #(
    parameter int WIDTH = 32
) (
    input logic       clk,
    input logic       rst,
    alu_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_t;

    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOV = 4'b1000;

    state_t           state_q;
    logic [3:0]       alu_ctrl_q;
    logic [WIDTH-1:0] alu_op1_q;
    logic [WIDTH-1:0] alu_op2_q;
    logic             err_q;

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] res_mem_q [2];
    logic [3:0]       flg_mem_q [2];
    logic             err_mem_q [2];

    logic             req_ready;
    logic             rsp_valid;
    logic             accept, push, pop, req_bad;
    logic [WIDTH-1:0] push_result;
    logic [3:0]       push_flags;

    // Count never reaches 2 while an operation is in flight, so push cannot overflow.
    assign req_ready   = (state_q == IDLE) && (count_q < 2'd2) && !rst;
    assign accept      = bus.req_valid && req_ready;
    assign req_bad     = (bus.req_op > OP_MOV) || ((bus.req_op == OP_DIV) && (bus.req_b == '0));
    assign push        = (state_q == CAPTURE);
    assign rsp_valid   = (count_q != 2'd0);
    assign pop         = rsp_valid && bus.rsp_ready;
    assign push_result = err_q ? '0 : bus.alu_result;
    assign push_flags  = err_q ? 4'b0 : bus.alu_flags;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            alu_ctrl_q <= 4'b0;
            alu_op1_q  <= '0;
            alu_op2_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        alu_ctrl_q <= req_bad ? OP_MOV : bus.req_op;
                        alu_op1_q  <= bus.req_a;
                        alu_op2_q  <= bus.req_b;
                        err_q      <= req_bad;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE:   state_q <= CAPTURE;
                CAPTURE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem_q[wr_ptr_q] <= push_result;
            flg_mem_q[wr_ptr_q] <= push_flags;
            err_mem_q[wr_ptr_q] <= err_q;
        end
    end

    // Storage is not reset; outputs are masked to zero whenever the FIFO is empty.
    assign bus.req_ready  = req_ready;
    assign bus.alu_ctrl   = alu_ctrl_q;
    assign bus.alu_op1    = alu_op1_q;
    assign bus.alu_op2    = alu_op2_q;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_valid ? res_mem_q[rd_ptr_q] : '0;
    assign bus.rsp_flags  = rsp_valid ? flg_mem_q[rd_ptr_q] : 4'b0;
    assign bus.rsp_err    = rsp_valid ? err_mem_q[rd_ptr_q] : 1'b0;

`ifdef ALU_DRIVER_STICKY_FLAGS_EN
    logic [3:0] sticky_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 4'b0;
        end else if (bus.sticky_clr) begin
            sticky_q <= 4'b0;
        end else if (push) begin
            sticky_q <= sticky_q | push_flags;
        end
    end

    assign bus.sticky_flags = sticky_q;
`else
    logic sticky_clr_unused;

    assign sticky_clr_unused = bus.sticky_clr;
    assign bus.sticky_flags  = 4'b0;
`endif
endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver with a behavioural ALU on the alu_* side.
module tb_alu_driver;
    localparam int WIDTH = 32;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MOV = 4'b1000;

`ifdef ALU_DRIVER_STICKY_FLAGS_EN
    localparam logic [3:0] STICKY_SUB = 4'b1010;
`else
    localparam logic [3:0] STICKY_SUB = 4'b0000;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_driver_if #(.WIDTH(WIDTH)) bus ();

    alu_driver #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural ALU, flags = {N, Z, C, V}; C is carry for add, borrow for sub.
    logic [WIDTH:0]   mdl_wide;
    logic [WIDTH-1:0] mdl_r;
    logic             mdl_c, mdl_v;

    always_comb begin
        mdl_wide = '0;
        mdl_r    = '0;
        mdl_c    = 1'b0;
        mdl_v    = 1'b0;
        case (bus.alu_ctrl)
            OP_ADD: begin
                mdl_wide = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
                mdl_r    = mdl_wide[WIDTH-1:0];
                mdl_c    = mdl_wide[WIDTH];
                mdl_v    = (bus.alu_op1[WIDTH-1] == bus.alu_op2[WIDTH-1]) && (mdl_r[WIDTH-1] != bus.alu_op1[WIDTH-1]);
            end
            OP_SUB: begin
                mdl_wide = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2};
                mdl_r    = mdl_wide[WIDTH-1:0];
                mdl_c    = mdl_wide[WIDTH];
                mdl_v    = (bus.alu_op1[WIDTH-1] != bus.alu_op2[WIDTH-1]) && (mdl_r[WIDTH-1] != bus.alu_op1[WIDTH-1]);
            end
            OP_MUL:  mdl_r = bus.alu_op1 * bus.alu_op2;
            OP_DIV:  mdl_r = (bus.alu_op2 == '0) ? '0 : bus.alu_op1 / bus.alu_op2;
            OP_AND:  mdl_r = bus.alu_op1 & bus.alu_op2;
            4'b0101: mdl_r = bus.alu_op1 | bus.alu_op2;
            OP_SHL:  mdl_r = bus.alu_op1 << bus.alu_op2[4:0];
            OP_SHR:  mdl_r = bus.alu_op1 >> bus.alu_op2[4:0];
            OP_MOV:  mdl_r = bus.alu_op2;
            default: mdl_r = '0;
        endcase
        bus.alu_result = mdl_r;
        bus.alu_flags  = {mdl_r[WIDTH-1], (mdl_r == '0), mdl_c, mdl_v};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
    endtask

    // Full transaction starting from IDLE with rsp_ready=1 and an empty or popping FIFO.
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] exp_ctrl, input logic [31:0] exp_res,
                         input logic [3:0] exp_flags, input logic exp_err, input string tag);
        chk({tag, ".ready_idle"}, bus.req_ready, 1'b1);
        set_req(op, a, b);
        tick();
        bus.req_valid = 1'b0;
        chk({tag, ".ctrl"}, bus.alu_ctrl, exp_ctrl);
        chk({tag, ".ready_issue"}, bus.req_ready, 1'b0);
        tick();
        chk({tag, ".ready_capture"}, bus.req_ready, 1'b0);
        chk({tag, ".valid_capture"}, bus.rsp_valid, 1'b0);
        tick();
        chk({tag, ".valid"}, bus.rsp_valid, 1'b1);
        chk({tag, ".result"}, bus.rsp_result, exp_res);
        chk({tag, ".flags"}, bus.rsp_flags, exp_flags);
        chk({tag, ".err"}, bus.rsp_err, exp_err);
    endtask

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_op     = 4'b0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.rsp_ready  = 1'b0;
        bus.sticky_clr = 1'b0;
        tick();
        tick();

        chk("rst.req_ready", bus.req_ready, 1'b0);
        chk("rst.rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst.alu_ctrl", bus.alu_ctrl, 4'b0);
        chk("rst.alu_op1", bus.alu_op1, 32'd0);
        chk("rst.alu_op2", bus.alu_op2, 32'd0);
        chk("rst.rsp_result", bus.rsp_result, 32'd0);
        chk("rst.rsp_flags", bus.rsp_flags, 4'b0);
        chk("rst.rsp_err", bus.rsp_err, 1'b0);
        chk("rst.sticky", bus.sticky_flags, 4'b0);

        rst = 1'b0;
        #1;
        chk("rel.req_ready", bus.req_ready, 1'b1);

        // add 7+2 with explicit latency checks
        bus.rsp_ready = 1'b1;
        set_req(OP_ADD, 32'd7, 32'd2);
        tick();
        bus.req_valid = 1'b0;
        chk("add.alu_ctrl", bus.alu_ctrl, OP_ADD);
        chk("add.alu_op1", bus.alu_op1, 32'd7);
        chk("add.alu_op2", bus.alu_op2, 32'd2);
        chk("add.ready_issue", bus.req_ready, 1'b0);
        chk("add.valid_issue", bus.rsp_valid, 1'b0);
        tick();
        chk("add.valid_capture", bus.rsp_valid, 1'b0);
        tick();
        chk("add.valid", bus.rsp_valid, 1'b1);
        chk("add.result", bus.rsp_result, 32'd9);
        chk("add.err", bus.rsp_err, 1'b0);
        chk("add.ready_after", bus.req_ready, 1'b1);

        // back-to-back
        do_op(OP_SUB, 32'd7, 32'd2, OP_SUB, 32'd5, 4'b0000, 1'b0, "b2b.sub");
        do_op(OP_MUL, 32'd10, 32'd2, OP_MUL, 32'd20, 4'b0000, 1'b0, "b2b.mul");
        do_op(OP_AND, 32'd31, 32'd21, OP_AND, 32'd21, 4'b0000, 1'b0, "b2b.and");
        tick();
        chk("b2b.drained", bus.rsp_valid, 1'b0);

        // backpressure
        bus.rsp_ready = 1'b0;
        set_req(OP_SHL, 32'd31, 32'd5);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("bp.shl_valid", bus.rsp_valid, 1'b1);
        chk("bp.shl_result", bus.rsp_result, 32'd992);
        chk("bp.ready_one", bus.req_ready, 1'b1);
        set_req(OP_SHR, 32'd31, 32'd5);
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        chk("bp.head_held", bus.rsp_result, 32'd992);
        chk("bp.ready_full", bus.req_ready, 1'b0);
        set_req(OP_ADD, 32'd1, 32'd1);
        tick();
        chk("bp.wait_ready", bus.req_ready, 1'b0);
        chk("bp.wait_op1", bus.alu_op1, 32'd31);
        tick();
        chk("bp.wait_head", bus.rsp_result, 32'd992);
        chk("bp.wait_flags", bus.rsp_flags, 4'b0000);
        bus.rsp_ready = 1'b1;
        tick();
        chk("bp.pop1_valid", bus.rsp_valid, 1'b1);
        chk("bp.pop1_result", bus.rsp_result, 32'd0);
        chk("bp.pop1_flags", bus.rsp_flags, 4'b0100);
        chk("bp.pop1_ready", bus.req_ready, 1'b1);
        tick();
        bus.req_valid = 1'b0;
        chk("bp.pop2_valid", bus.rsp_valid, 1'b0);
        chk("bp.third_op1", bus.alu_op1, 32'd1);
        chk("bp.third_ready", bus.req_ready, 1'b0);
        tick();
        tick();
        chk("bp.third_valid", bus.rsp_valid, 1'b1);
        chk("bp.third_result", bus.rsp_result, 32'd2);

        // division and illegal opcodes
        do_op(OP_DIV, 32'd10, 32'd2, OP_DIV, 32'd5, 4'b0000, 1'b0, "err.div_ok");
        do_op(OP_DIV, 32'd10, 32'd0, OP_MOV, 32'd0, 4'b0000, 1'b1, "err.div0");
        do_op(4'b1010, 32'd5, 32'd6, OP_MOV, 32'd0, 4'b0000, 1'b1, "err.illegal");
        tick();
        chk("err.drained", bus.rsp_valid, 1'b0);

        // reset during ISSUE
        set_req(OP_ADD, 32'd7, 32'd2);
        tick();
        bus.req_valid = 1'b0;
        chk("mid.issue_op1", bus.alu_op1, 32'd7);
        rst = 1'b1;
        #1;
        chk("mid.req_ready", bus.req_ready, 1'b0);
        chk("mid.alu_ctrl", bus.alu_ctrl, 4'b0);
        chk("mid.alu_op1", bus.alu_op1, 32'd0);
        chk("mid.alu_op2", bus.alu_op2, 32'd0);
        chk("mid.rsp_valid", bus.rsp_valid, 1'b0);
        chk("mid.rsp_result", bus.rsp_result, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("mid.no_rsp", bus.rsp_valid, 1'b0);
        do_op(OP_ADD, 32'd3, 32'd4, OP_ADD, 32'd7, 4'b0000, 1'b0, "mid.next");
        tick();

        // sticky flags
        bus.sticky_clr = 1'b1;
        tick();
        bus.sticky_clr = 1'b0;
        chk("sticky.clr0", bus.sticky_flags, 4'b0);
        do_op(OP_SUB, 32'd2, 32'd7, OP_SUB, 32'hFFFF_FFFB, 4'b1010, 1'b0, "sticky.sub");
        chk("sticky.after_sub", bus.sticky_flags, STICKY_SUB);
        do_op(OP_ADD, 32'd7, 32'd2, OP_ADD, 32'd9, 4'b0000, 1'b0, "sticky.add");
        chk("sticky.after_add", bus.sticky_flags, STICKY_SUB);
        tick();
        bus.sticky_clr = 1'b1;
        tick();
        bus.sticky_clr = 1'b0;
        chk("sticky.clr1", bus.sticky_flags, 4'b0);
        set_req(OP_SUB, 32'd2, 32'd7);
        tick();
        bus.req_valid = 1'b0;
        tick();
        bus.sticky_clr = 1'b1;
        tick();
        bus.sticky_clr = 1'b0;
        chk("sticky.clr_wins_valid", bus.rsp_valid, 1'b1);
        chk("sticky.clr_wins", bus.sticky_flags, 4'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width, matching the Alu WIDTH parameter.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port req_valid, input, 1, the request is valid.
REQ-005 SHALL have port req_ready, output, 1, the request is accepted on a clk edge while req_valid=1.
REQ-006 SHALL have port req_op, input, 4, the ALU opcode.
REQ-007 SHALL have ports req_a and req_b, input, WIDTH, the operands.
REQ-008 SHALL have ports alu_ctrl (output, 4), alu_op1 (output, WIDTH) and alu_op2 (output, WIDTH), all registered and driving the Alu inputs.
REQ-009 SHALL have ports alu_result (input, WIDTH) and alu_flags (input, 4), the combinational Alu outputs.
REQ-010 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1), the response handshake.
REQ-011 SHALL have ports rsp_result (output, WIDTH), rsp_flags (output, 4) and rsp_err (output, 1), the head of the response FIFO.
REQ-012 SHALL have ports sticky_flags (output, 4) and sticky_clr (input, 1), the accumulated flags, see Configuration.

Function
REQ-013 SHALL support legal opcodes 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 shl, 0111 shr and 1000 mov; 1001-1111 are illegal.
REQ-014 SHALL implement an FSM with states IDLE, ISSUE and CAPTURE; only one operation is in flight at a time.
REQ-015 SHALL drive req_ready=1 only in IDLE and only when the FIFO count is less than 2.
REQ-016 SHALL, in IDLE on req_valid&&req_ready, load alu_ctrl/alu_op1/alu_op2 from req_op/req_a/req_b and go to ISSUE.
REQ-017 SHALL hold the ALU inputs stable for the full ISSUE cycle (settle cycle for the combinational Alu), then go unconditionally to CAPTURE.
REQ-018 SHALL, in CAPTURE, push {alu_result, alu_flags, err=0} into the FIFO and return to IDLE.
REQ-019 SHALL make rsp_valid visible after the 2nd rising edge following the accepting edge, giving a throughput of 1 operation per 3 cycles.
REQ-020 SHALL, for an illegal opcode, drive alu_ctrl=1000, follow identical timing, and push result=0, flags=0, err=1.
REQ-021 SHALL, for div with req_b=0, drive alu_ctrl=1000, follow identical timing, and push result=0, flags=0, err=1.
REQ-022 SHALL implement the FIFO as a 2-entry in-order buffer with rsp_valid = (count != 0).
REQ-023 SHALL pop the FIFO on rsp_valid&&rsp_ready.
REQ-024 SHALL, on a simultaneous push and pop, leave count unchanged and preserve order.
REQ-025 SHALL hold the rsp_* outputs stable while rsp_valid=1 and rsp_ready=0.
REQ-026 SHALL never overflow the FIFO; overflow is structurally impossible through REQ-015.

Reset
REQ-027 SHALL, on rst, immediately place the FSM in IDLE, empty the FIFO and drive all outputs to 0: req_ready=0 while rst is high, alu_* = 0, rsp_* = 0, sticky_flags=0.
REQ-028 SHALL, on rst asserted mid-operation (ISSUE or CAPTURE), discard the in-flight operation without pushing a response.
REQ-029 SHALL assert req_ready on the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, when macro ALU_DRIVER_STICKY_FLAGS_EN is defined, update sticky_flags in CAPTURE as sticky_flags |= pushed flags.
REQ-031 SHALL, with ALU_DRIVER_STICKY_FLAGS_EN defined, clear sticky_flags on sticky_clr=1; if sticky_clr coincides with CAPTURE, the clear wins and the new flags are not added.
REQ-032 SHALL, without ALU_DRIVER_STICKY_FLAGS_EN, tie sticky_flags to 0, ignore sticky_clr and keep the ports present.

Verification
REQ-033 SHALL cover add: op=0000, a=7, b=2, rsp_ready=1 -> rsp_result=9, rsp_err=0, rsp_valid 2 edges after accept.
REQ-034 SHALL cover back-to-back ops: sub 7-2, mul 10*2, and 31&21 -> responses 5, 20, 21 in order, req_ready low in ISSUE/CAPTURE.
REQ-035 SHALL cover backpressure: rsp_ready=0, issue shl 31<<5 then shr 31>>5 -> count=2, req_ready stays 0; a 3rd request waits; raise rsp_ready -> 992 then 0 pop in order, then the 3rd request is accepted.
REQ-036 SHALL cover errors: div a=10, b=0 -> err=1, result=0; op=1010 -> err=1, alu_ctrl observed 1000.
REQ-037 SHALL cover reset mid-operation: assert rst during ISSUE of add 7+2 -> all outputs 0, no response after release, next request handled normally.
REQ-038 SHALL cover sticky flags (macro defined): sub 2-7 then add 7+2 -> sticky_flags equals the OR of both flag sets; pulse sticky_clr -> 0; without the macro, sticky_flags stays 0 throughout.
